// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types for the data-memory arbiter:
//   arb_state_t : arbiter FSM state (IDLE, CPU_RD, LD_RD)
//   grant_t     : who owns the memory port in a grant cycle
//   arbitrate() : fixed-priority grant rule with loader anti-starvation
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    LD_RD  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_LD   = 2'd2
  } grant_t;

  // The CPU normally wins a tie; the loader wins when the CPU is absent or when
  // it has been refused long enough to be starved.
  function automatic grant_t arbitrate(input logic cpu_req,
                                       input logic ld_req,
                                       input logic starved);
    if (ld_req && (starved || !cpu_req)) return GNT_LD;
    if (cpu_req)                          return GNT_CPU;
    return GNT_NONE;
  endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// -----------------------------------------------------------------------------
// dmem_arb_if
// Bundle of every bus the arbiter touches: the CPU memory-stage port
// (cpu_*), the boot/program loader port (ld_*) and the physical single-port
// data memory (mem_*).
//   slave  : the arbiter's view
//   master : the surrounding system's view (CPU, loader and memory together)
// -----------------------------------------------------------------------------
interface dmem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // CPU memory-access stage
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  // Loader
  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_ready;
  logic              ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;

  // Physical data memory
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_ready, ld_rvalid, ld_rdata,
    output mem_we, mem_addr, mem_din,
    input  mem_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_ready, ld_rvalid, ld_rdata,
    input  mem_we, mem_addr, mem_din,
    output mem_dout
  );

endinterface

// File: rtl/dmem_arb_starve_cnt.sv
// -----------------------------------------------------------------------------
// dmem_arb_starve_cnt
// Saturating counter of consecutive refused loader requests.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   inc       : loader request refused this cycle
//   clr       : loader granted, or loader not requesting (clr wins over inc)
//   at_limit  : counter has reached LIMIT; loader must be granted next
// -----------------------------------------------------------------------------
module dmem_arb_starve_cnt #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign at_limit = (cnt_q == CNT_W'(LIMIT));

  // NOTE: cnt_d gets a default before any branch so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                  cnt_d = '0;
    else if (inc && !at_limit) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the CPU memory-access stage and
// the boot/program loader. Writes complete in the grant cycle; reads park the
// FSM for MEM_LAT cycles and deliver mem_dout combinationally in the last one,
// which is kept memory-idle. cpu_stall freezes the pipeline while a CPU read is
// outstanding, while the CPU has lost arbitration, or while a loader read owns
// the memory.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   bus (slave)    : cpu_*, ld_* and mem_* signals, see dmem_arb_if
//   stall_cycles   : (DMEM_ARB_PERF_EN only) cycles with cpu_stall=1, wraps
//   ld_grants      : (DMEM_ARB_PERF_EN only) cycles with ld_ready=1, wraps
// Build option: define DMEM_ARB_PERF_EN to add the two performance counters.
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 2,   // >= 1
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  dmem_arb_if.slave   bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] ld_grants
`endif
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);

  arb_state_t        state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;

  grant_t grant;
  logic   starved;
  logic   deliver;

  // Grants happen only in IDLE. Gating with rst makes every output take its
  // reset value immediately when rst rises, even with requests still present.
  always_comb begin
    grant = GNT_NONE;
    if (!rst && state_q == IDLE) grant = arbitrate(bus.cpu_req, bus.ld_req, starved);
  end

  // Last latency cycle of a read: memory data is valid and the port is idle.
  assign deliver = (state_q != IDLE) && (lat_q == LAT_W'(MEM_LAT));

  dmem_arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      ((state_q == IDLE) && bus.ld_req && (grant != GNT_LD)),
    .clr      (!bus.ld_req || (grant == GNT_LD)),
    .at_limit (starved)
  );

  always_comb begin
    state_d       = state_q;
    lat_d         = lat_q;
    addr_d        = addr_q;
    din_d         = din_q;
    cpu_rdata_d   = cpu_rdata_q;
    ld_rdata_d    = ld_rdata_q;
    bus.mem_we    = 1'b0;
    bus.cpu_stall = 1'b0;
    bus.ld_ready  = 1'b0;
    bus.ld_rvalid = 1'b0;

    case (grant)
      GNT_CPU: begin
        addr_d     = bus.cpu_addr;
        din_d      = bus.cpu_wdata;
        bus.mem_we = bus.cpu_we;
        if (!bus.cpu_we) begin
          state_d       = CPU_RD;
          lat_d         = LAT_W'(1);
          bus.cpu_stall = 1'b1;
        end
      end
      GNT_LD: begin
        addr_d        = bus.ld_addr;
        din_d         = bus.ld_wdata;
        bus.mem_we    = bus.ld_we;
        bus.ld_ready  = 1'b1;
        bus.cpu_stall = bus.cpu_req;   // CPU lost; it re-arbitrates next cycle
        if (!bus.ld_we) begin
          state_d = LD_RD;
          lat_d   = LAT_W'(1);
        end
      end
      default: ;
    endcase

    case (state_q)
      CPU_RD: begin
        bus.cpu_stall = !deliver;
        if (deliver) begin
          cpu_rdata_d = bus.mem_dout;
          state_d     = IDLE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      LD_RD: begin
        // Any CPU access waits until the loader read has fully drained.
        bus.cpu_stall = bus.cpu_req;
        if (deliver) begin
          bus.ld_rvalid = 1'b1;
          ld_rdata_d    = bus.mem_dout;
          state_d       = IDLE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // The _d values carry the grant-cycle drive and the delivery-cycle bypass;
  // in every other cycle they equal the held registers.
  assign bus.mem_addr  = addr_d;
  assign bus.mem_din   = din_d;
  assign bus.cpu_rdata = cpu_rdata_d;
  assign bus.ld_rdata  = ld_rdata_d;

  // NOTE: the data hold registers are reset as well because their values are
  // visible on the outputs straight after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] ld_grants_q, ld_grants_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + 32'(bus.cpu_stall);
    ld_grants_d    = ld_grants_q + 32'(bus.ld_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      ld_grants_q    <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      ld_grants_q    <= ld_grants_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign ld_grants    = ld_grants_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter: a directed cycle table, hand-written
// reset-during-read and perf-counter sequences, then randomized traffic
// compared against a cycle-count reference model. A fixed-latency memory model
// with pipelined read data drives mem_dout.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 2;
  localparam int LIMIT   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] stall_cycles, ld_grants;
`endif

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef DMEM_ARB_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .ld_grants    (ld_grants)
`endif
  );

  // ---------------- memory model: 256 words, read latency MEM_LAT ----------
  logic [31:0] mem [0:255];
  logic [31:0] rd_pipe [0:MEM_LAT-1];

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE0000 | 32'(i);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      for (int i = 0; i < MEM_LAT; i++) rd_pipe[i] <= '0;
    end else begin
      if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_din;
      rd_pipe[0] <= mem[bus.mem_addr[9:2]];
      for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end
  assign bus.mem_dout = rd_pipe[MEM_LAT-1];

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // expected outputs of the current cycle
  logic        e_mwe, e_stall, e_rdy, e_rv;
  logic [31:0] e_maddr, e_mdin, e_crd, e_lrd;

  task automatic compare_outputs(input string tag);
    check({tag, ".mem_we"},    32'(bus.mem_we),    32'(e_mwe));
    check({tag, ".mem_addr"},  bus.mem_addr,       e_maddr);
    check({tag, ".mem_din"},   bus.mem_din,        e_mdin);
    check({tag, ".cpu_stall"}, 32'(bus.cpu_stall), 32'(e_stall));
    check({tag, ".cpu_rdata"}, bus.cpu_rdata,      e_crd);
    check({tag, ".ld_ready"},  32'(bus.ld_ready),  32'(e_rdy));
    check({tag, ".ld_rvalid"}, 32'(bus.ld_rvalid), 32'(e_rv));
    check({tag, ".ld_rdata"},  bus.ld_rdata,       e_lrd);
  endtask

  task automatic idle_inputs();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ld_req  = 1'b0; bus.ld_we  = 1'b0; bus.ld_addr  = '0; bus.ld_wdata  = '0;
  endtask

  task automatic do_reset(input bit check_outputs);
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    if (check_outputs) begin
      e_mwe = 0; e_maddr = 0; e_mdin = 0; e_stall = 0;
      e_crd = 0; e_rdy = 0; e_rv = 0; e_lrd = 0;
      compare_outputs("reset");
    end
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic        lr, lw;
    logic [31:0] la, ld;
    logic        mwe;
    logic [31:0] maddr, mdin;
    logic        stall;
    logic [31:0] crd;
    logic        rdy, rv;
    logic [31:0] lrd;
  } vec_t;

  function automatic vec_t mk(
    input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
    input logic lr, input logic lw, input logic [31:0] la, input logic [31:0] ld,
    input logic mwe, input logic [31:0] maddr, input logic [31:0] mdin,
    input logic stall, input logic [31:0] crd,
    input logic rdy, input logic rv, input logic [31:0] lrd);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.lr = lr; v.lw = lw; v.la = la; v.ld = ld;
    v.mwe = mwe; v.maddr = maddr; v.mdin = mdin; v.stall = stall;
    v.crd = crd; v.rdy = rdy; v.rv = rv; v.lrd = lrd;
    return v;
  endfunction

  vec_t vecs [0:18];

  // Cycle-by-cycle from reset release. Memory word i initially holds C0DE0000|i.
  task automatic fill_table();
    // store 0x100 <- DEADBEEF: zero-latency write
    vecs[0]  = mk(1,1,32'h100,32'hDEADBEEF, 0,0,0,0, 1,32'h100,32'hDEADBEEF, 0,0, 0,0,0);
    // load 0x100 at T: stall T, T+1; data at T+2
    vecs[1]  = mk(1,0,32'h100,0, 0,0,0,0, 0,32'h100,0, 1,0, 0,0,0);
    vecs[2]  = mk(1,0,32'h100,0, 0,0,0,0, 0,32'h100,0, 1,0, 0,0,0);
    vecs[3]  = mk(1,0,32'h100,0, 0,0,0,0, 0,32'h100,0, 0,32'hDEADBEEF, 0,0,0);
    // next load granted at T+3
    vecs[4]  = mk(1,0,32'h104,0, 0,0,0,0, 0,32'h104,0, 1,32'hDEADBEEF, 0,0,0);
    vecs[5]  = mk(1,0,32'h104,0, 0,0,0,0, 0,32'h104,0, 1,32'hDEADBEEF, 0,0,0);
    vecs[6]  = mk(1,0,32'h104,0, 0,0,0,0, 0,32'h104,0, 0,32'hC0DE0041, 0,0,0);
    // both requesting writes: CPU x4, loader forced on the 5th, then CPU again
    for (int i = 7; i <= 10; i++)
      vecs[i] = mk(1,1,32'h200,32'h11111111, 1,1,32'h300,32'h22222222,
                   1,32'h200,32'h11111111, 0,32'hC0DE0041, 0,0,0);
    vecs[11] = mk(1,1,32'h200,32'h11111111, 1,1,32'h300,32'h22222222,
                  1,32'h300,32'h22222222, 1,32'hC0DE0041, 1,0,0);
    vecs[12] = mk(1,1,32'h200,32'h11111111, 1,1,32'h300,32'h22222222,
                  1,32'h200,32'h11111111, 0,32'hC0DE0041, 0,0,0);
    // loader read 0x40 at T; CPU load arrives at T+1 and waits for IDLE
    vecs[13] = mk(0,0,0,0, 1,0,32'h40,0, 0,32'h40,0, 0,32'hC0DE0041, 1,0,0);
    vecs[14] = mk(1,0,32'h100,0, 0,0,0,0, 0,32'h40,0, 1,32'hC0DE0041, 0,0,0);
    vecs[15] = mk(1,0,32'h100,0, 0,0,0,0, 0,32'h40,0, 1,32'hC0DE0041, 0,1,32'hC0DE0010);
    vecs[16] = mk(1,0,32'h100,0, 0,0,0,0, 0,32'h100,0, 1,32'hC0DE0041, 0,0,32'hC0DE0010);
    vecs[17] = mk(1,0,32'h100,0, 0,0,0,0, 0,32'h100,0, 1,32'hC0DE0041, 0,0,32'hC0DE0010);
    vecs[18] = mk(1,0,32'h100,0, 0,0,0,0, 0,32'h100,0, 0,32'hDEADBEEF, 0,0,32'hC0DE0010);
  endtask

  // Issue a CPU load and wait (bounded) for the cycle in which the stall drops.
  task automatic cpu_load(input logic [31:0] addr, input logic [31:0] exp_data, input string tag);
    int stalls = 0;
    bit done = 0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = addr; bus.cpu_wdata = '0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (!bus.cpu_stall) begin
        done = 1;
        check({tag, ".rdata"}, bus.cpu_rdata, exp_data);
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    bus.cpu_req = 1'b0;
    check({tag, ".completed"}, 32'(done), 32'd1);
    check({tag, ".stall_len"}, 32'(stalls), 32'(MEM_LAT));
  endtask

  // ---------------- reference model (cycle-number bookkeeping) ----------------
  int          m_n, m_free_at, m_deliver_at, m_reader, m_starve;
  logic [31:0] m_rd_word, m_cpu_hold, m_ld_hold, m_last_addr, m_last_din;

  task automatic model_reset();
    m_n = 0; m_free_at = 0; m_deliver_at = -1; m_reader = 0; m_starve = 0;
    m_rd_word = 0; m_cpu_hold = 0; m_ld_hold = 0; m_last_addr = 0; m_last_din = 0;
  endtask

  // Produce this cycle's expected outputs from the current inputs, then move on.
  task automatic model_eval();
    bit idle = (m_n >= m_free_at);
    int who  = 0;   // 0 none, 1 cpu, 2 loader
    e_mwe = 0; e_maddr = m_last_addr; e_mdin = m_last_din; e_stall = 0;
    e_rdy = 0; e_rv = 0; e_crd = m_cpu_hold; e_lrd = m_ld_hold;
    if (idle) begin
      if (bus.ld_req && (m_starve == LIMIT || !bus.cpu_req)) who = 2;
      else if (bus.cpu_req)                                 who = 1;
      if (who == 1) begin
        e_mwe = bus.cpu_we; e_maddr = bus.cpu_addr; e_mdin = bus.cpu_wdata;
        e_stall = !bus.cpu_we;
      end else if (who == 2) begin
        e_mwe = bus.ld_we; e_maddr = bus.ld_addr; e_mdin = bus.ld_wdata;
        e_rdy = 1; e_stall = bus.cpu_req;
      end
      if (who != 0 && !e_mwe) begin
        m_reader     = who;
        m_deliver_at = m_n + MEM_LAT;
        m_free_at    = m_deliver_at + 1;
        m_rd_word    = mem[e_maddr[9:2]];
      end
      if (!bus.ld_req || who == 2) m_starve = 0;
      else if (m_starve < LIMIT)   m_starve++;
    end else begin
      e_stall = (m_reader == 1) ? (m_n < m_deliver_at) : bus.cpu_req;
      if (m_n == m_deliver_at) begin
        if (m_reader == 1) begin
          e_crd = m_rd_word; m_cpu_hold = m_rd_word;
        end else begin
          e_rv = 1; e_lrd = m_rd_word; m_ld_hold = m_rd_word;
        end
      end
      if (!bus.ld_req) m_starve = 0;
    end
    m_last_addr = e_maddr;
    m_last_din  = e_mdin;
    m_n++;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    idle_inputs();

    // reset state and directed table
    do_reset(1'b1);
    fill_table();
    for (int i = 0; i < 19; i++) begin
      bus.cpu_req = vecs[i].cr; bus.cpu_we = vecs[i].cw;
      bus.cpu_addr = vecs[i].ca; bus.cpu_wdata = vecs[i].cd;
      bus.ld_req = vecs[i].lr; bus.ld_we = vecs[i].lw;
      bus.ld_addr = vecs[i].la; bus.ld_wdata = vecs[i].ld;
      e_mwe = vecs[i].mwe; e_maddr = vecs[i].maddr; e_mdin = vecs[i].mdin;
      e_stall = vecs[i].stall; e_crd = vecs[i].crd; e_rdy = vecs[i].rdy;
      e_rv = vecs[i].rv; e_lrd = vecs[i].lrd;
      @(negedge clk);
      compare_outputs($sformatf("vec%0d", i));
      @(posedge clk); #1;
    end
    idle_inputs();
    @(posedge clk); #1;

    // rst asserted one cycle into a CPU read
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h104;
    @(negedge clk);
    check("rstmid.grant_stall", 32'(bus.cpu_stall), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    e_mwe = 0; e_maddr = 0; e_mdin = 0; e_stall = 0;
    e_crd = 0; e_rdy = 0; e_rv = 0; e_lrd = 0;
    compare_outputs("rstmid");
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < MEM_LAT + 2; c++) begin
      @(negedge clk);
      check($sformatf("rstmid.c%0d.ld_rvalid", c), 32'(bus.ld_rvalid), 32'd0);
      check($sformatf("rstmid.c%0d.cpu_stall", c), 32'(bus.cpu_stall), 32'd0);
      check($sformatf("rstmid.c%0d.cpu_rdata", c), bus.cpu_rdata, 32'd0);
      @(posedge clk); #1;
    end
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h108; bus.cpu_wdata = 32'h5A5A5A5A;
    @(negedge clk);
    check("post_rst.store.mem_we",   32'(bus.mem_we), 32'd1);
    check("post_rst.store.mem_addr", bus.mem_addr, 32'h108);
    check("post_rst.store.stall",    32'(bus.cpu_stall), 32'd0);
    @(posedge clk); #1;
    cpu_load(32'h108, 32'h5A5A5A5A, "post_rst.load");

`ifdef DMEM_ARB_PERF_EN
    do_reset(1'b0);
    cpu_load(32'h100, init_word(64), "perf.load0");
    cpu_load(32'h100, init_word(64), "perf.load1");
    check("perf.stall_cycles", stall_cycles, 32'd4);
    check("perf.ld_grants",    ld_grants,    32'd0);
`endif

    // randomized traffic against the reference model
    do_reset(1'b0);
    model_reset();
    begin
      bit cpu_hold = 0;
      bit ld_hold  = 0;
      for (int c = 0; c < 3000; c++) begin
        if (!cpu_hold) begin
          bus.cpu_req   = ($urandom_range(0, 99) < 60);
          bus.cpu_we    = 1'($urandom_range(0, 1));
          bus.cpu_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
          bus.cpu_wdata = $urandom;
        end
        if (!ld_hold) begin
          bus.ld_req   = ($urandom_range(0, 99) < 45);
          bus.ld_we    = 1'($urandom_range(0, 1));
          bus.ld_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
          bus.ld_wdata = $urandom;
        end
        @(negedge clk);
        model_eval();
        compare_outputs($sformatf("rnd%0d", c));
        // pipeline and loader keep a request stable until it is served
        cpu_hold = bus.cpu_req && e_stall;
        ld_hold  = bus.ld_req && !e_rdy;
        @(posedge clk); #1;
      end
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
